// File: rtl/anabellek_hakem.sv
// Main-memory arbiter between the instruction cache (bbellek) and data cache (vbellek).
// Each granted 128-bit block moves as four separate 32-bit iomem beats.
module anabellek_hakem #(
  parameter int unsigned ZAMAN_ASIMI = 1024,
  parameter int unsigned SAYAC_BIT   = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bbellek_istek_i,
  input  logic [31:0]  bbellek_adres_i,
  input  logic         vbellek_istek_i,
  input  logic         vbellek_yaz_i,
  input  logic [31:0]  vbellek_adres_i,
  input  logic [127:0] yazilacak_veri_obegi_i,
  input  logic         iomem_ready_i,
  input  logic [31:0]  iomem_rdata_i,
  output logic         iomem_valid_o,
  output logic [31:0]  iomem_addr_o,
  output logic [31:0]  iomem_wdata_o,
  output logic [3:0]   iomem_wstrb_o,
  output logic         anabellek_musait_o,
  output logic [127:0] okunan_veri_obegi_o,
  output logic         bbellek_hazir_o,
  output logic         vbellek_hazir_o,
  output logic         hata_o
);

  typedef enum logic [1:0] {BOSTA, ISTEK, ARA, TAMAM} durum_t;

  localparam logic [SAYAC_BIT-1:0] SAYAC_SON =
    SAYAC_BIT'((ZAMAN_ASIMI == 0) ? 0 : ZAMAN_ASIMI - 1);

  durum_t               durum;
  logic                 sahip_v;
  logic                 son_v;
  logic                 yaz_r;
  logic [27:0]          adres_r;
  logic [127:0]         blok_r;
  logic [1:0]           beat;
  logic [SAYAC_BIT-1:0] sayac;

  logic        secim_v;
  logic        secim_yaz;
  logic [31:0] secim_adres;
  logic        zaman_doldu;
  logic        unused_alt_bitler;

  // Both requesting: the one that did not win last time gets the port.
  always_comb begin
    secim_v = vbellek_istek_i;
    if (bbellek_istek_i && vbellek_istek_i) secim_v = !son_v;
  end

  assign secim_yaz         = secim_v & vbellek_yaz_i;
  assign secim_adres       = secim_v ? vbellek_adres_i : bbellek_adres_i;
  assign zaman_doldu       = (ZAMAN_ASIMI != 0) && (sayac == SAYAC_SON);
  assign unused_alt_bitler = ^secim_adres[3:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum               <= BOSTA;
      sahip_v             <= 1'b0;
      son_v               <= 1'b1;
      yaz_r               <= 1'b0;
      adres_r             <= '0;
      blok_r              <= '0;
      beat                <= '0;
      sayac               <= '0;
      iomem_valid_o       <= 1'b0;
      iomem_addr_o        <= '0;
      iomem_wdata_o       <= '0;
      iomem_wstrb_o       <= '0;
      anabellek_musait_o  <= 1'b1;
      okunan_veri_obegi_o <= '0;
      bbellek_hazir_o     <= 1'b0;
      vbellek_hazir_o     <= 1'b0;
      hata_o              <= 1'b0;
    end else begin
      bbellek_hazir_o <= 1'b0;
      vbellek_hazir_o <= 1'b0;
      hata_o          <= 1'b0;
      case (durum)
        BOSTA: begin
          if (bbellek_istek_i || vbellek_istek_i) begin
            sahip_v            <= secim_v;
            son_v              <= secim_v;
            yaz_r              <= secim_yaz;
            adres_r            <= secim_adres[31:4];
            blok_r             <= yazilacak_veri_obegi_i;
            beat               <= '0;
            sayac              <= '0;
            anabellek_musait_o <= 1'b0;
            // Beat 0 is driven straight from the grant inputs.
            iomem_valid_o      <= 1'b1;
            iomem_addr_o       <= {secim_adres[31:4], 4'b0000};
            iomem_wdata_o      <= secim_yaz ? yazilacak_veri_obegi_i[31:0] : '0;
            iomem_wstrb_o      <= secim_yaz ? 4'hF : 4'h0;
            durum              <= ISTEK;
          end
        end
        ISTEK: begin
          if (iomem_ready_i) begin
            if (!yaz_r) okunan_veri_obegi_o[{beat, 5'b00000} +: 32] <= iomem_rdata_i;
            sayac         <= '0;
            iomem_valid_o <= 1'b0;
            iomem_wdata_o <= '0;
            iomem_wstrb_o <= '0;
            if (beat == 2'd3) begin
              bbellek_hazir_o <= !sahip_v;
              vbellek_hazir_o <= sahip_v;
              durum           <= TAMAM;
            end else begin
              beat  <= beat + 2'd1;
              durum <= ARA;
            end
          end else if (zaman_doldu) begin
            sayac           <= '0;
            iomem_valid_o   <= 1'b0;
            iomem_wdata_o   <= '0;
            iomem_wstrb_o   <= '0;
            bbellek_hazir_o <= !sahip_v;
            vbellek_hazir_o <= sahip_v;
            hata_o          <= 1'b1;
            durum           <= TAMAM;
          end else begin
            sayac <= sayac + 1'b1;
          end
        end
        ARA: begin
          iomem_valid_o <= 1'b1;
          iomem_addr_o  <= {adres_r, beat, 2'b00};
          iomem_wdata_o <= yaz_r ? blok_r[{beat, 5'b00000} +: 32] : '0;
          iomem_wstrb_o <= yaz_r ? 4'hF : 4'h0;
          durum         <= ISTEK;
        end
        TAMAM: begin
          anabellek_musait_o <= 1'b1;
          durum              <= BOSTA;
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Directed bench for anabellek_hakem: a simple iomem responder with programmable latency
// and hand-computed expectations for reads, write-back, arbitration, timeout and reset.
module tb_anabellek_hakem;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         bbellek_istek_i;
  logic [31:0]  bbellek_adres_i;
  logic         vbellek_istek_i;
  logic         vbellek_yaz_i;
  logic [31:0]  vbellek_adres_i;
  logic [127:0] yazilacak_veri_obegi_i;
  logic         iomem_ready_i;
  logic [31:0]  iomem_rdata_i;
  logic         iomem_valid_o;
  logic [31:0]  iomem_addr_o;
  logic [31:0]  iomem_wdata_o;
  logic [3:0]   iomem_wstrb_o;
  logic         anabellek_musait_o;
  logic [127:0] okunan_veri_obegi_o;
  logic         bbellek_hazir_o;
  logic         vbellek_hazir_o;
  logic         hata_o;

  anabellek_hakem #(.ZAMAN_ASIMI(8), .SAYAC_BIT(4)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .bbellek_istek_i        (bbellek_istek_i),
    .bbellek_adres_i        (bbellek_adres_i),
    .vbellek_istek_i        (vbellek_istek_i),
    .vbellek_yaz_i          (vbellek_yaz_i),
    .vbellek_adres_i        (vbellek_adres_i),
    .yazilacak_veri_obegi_i (yazilacak_veri_obegi_i),
    .iomem_ready_i          (iomem_ready_i),
    .iomem_rdata_i          (iomem_rdata_i),
    .iomem_valid_o          (iomem_valid_o),
    .iomem_addr_o           (iomem_addr_o),
    .iomem_wdata_o          (iomem_wdata_o),
    .iomem_wstrb_o          (iomem_wstrb_o),
    .anabellek_musait_o     (anabellek_musait_o),
    .okunan_veri_obegi_o    (okunan_veri_obegi_o),
    .bbellek_hazir_o        (bbellek_hazir_o),
    .vbellek_hazir_o        (vbellek_hazir_o),
    .hata_o                 (hata_o)
  );

  always #5 clk = ~clk;

  int          hata_sayisi = 0;
  int          kontrol_sayisi = 0;
  int          gecikme = 0;
  int          bekle = 0;
  logic        mem_acik = 1'b1;
  logic [31:0] veri_taban = 32'h0;
  logic [31:0] adr_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];

  // Memory model: ready after 'gecikme' waiting cycles; read data = base + beat index.
  always @(negedge clk) begin
    if (iomem_valid_o && mem_acik) begin
      if (bekle >= gecikme) begin
        iomem_ready_i = 1'b1;
        iomem_rdata_i = veri_taban + {30'b0, iomem_addr_o[3:2]};
        adr_q.push_back(iomem_addr_o);
        wd_q.push_back(iomem_wdata_o);
        ws_q.push_back(iomem_wstrb_o);
        bekle = 0;
      end else begin
        iomem_ready_i = 1'b0;
        bekle++;
      end
    end else begin
      iomem_ready_i = 1'b0;
      bekle = 0;
    end
  end

  task automatic kontrol(input string etiket, input logic [127:0] gozlenen,
                         input logic [127:0] beklenen);
    kontrol_sayisi++;
    if (gozlenen !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic kuyruk_temizle();
    adr_q.delete();
    wd_q.delete();
    ws_q.delete();
  endtask

  // Called on a negedge where no hazir is high; returns cycles until hazir and the valid trace.
  task automatic hazir_bekle(output int n, output logic [15:0] iz, output logic musait1);
    n = 0;
    iz = '0;
    musait1 = 1'b1;
    while (!(bbellek_hazir_o || vbellek_hazir_o) && n < 200) begin
      @(negedge clk);
      n++;
      if (n <= 16) iz[n-1] = iomem_valid_o;
      if (n == 1) musait1 = anabellek_musait_o;
    end
    if (!(bbellek_hazir_o || vbellek_hazir_o)) kontrol("hazir_bekle", 0, 1);
  endtask

  task automatic beatler_kontrol(input string etiket, input logic [31:0] taban,
                                 input logic [127:0] blok, input logic [3:0] strb);
    logic [31:0] kelime;
    kontrol({etiket, "_beat_sayisi"}, adr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < adr_q.size()) begin
        kelime = blok[i*32 +: 32];
        kontrol($sformatf("%s_adr%0d", etiket, i), adr_q[i], taban + 32'(4 * i));
        kontrol($sformatf("%s_wdata%0d", etiket, i), wd_q[i], kelime);
        kontrol($sformatf("%s_wstrb%0d", etiket, i), ws_q[i], strb);
      end
    end
  endtask

  function automatic logic [127:0] okuma_blogu(input logic [31:0] t);
    return {t + 32'd3, t + 32'd2, t + 32'd1, t};
  endfunction

  task automatic sifirla();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  int          n;
  logic [15:0] iz;
  logic        m1;
  logic        gorulen;
  int          sinir;

  initial begin
    rst_i = 1'b1;
    bbellek_istek_i = 1'b0;
    bbellek_adres_i = '0;
    vbellek_istek_i = 1'b0;
    vbellek_yaz_i = 1'b0;
    vbellek_adres_i = '0;
    yazilacak_veri_obegi_i = '0;
    iomem_ready_i = 1'b0;
    iomem_rdata_i = '0;

    repeat (2) @(negedge clk);
    kontrol("rst_musait", anabellek_musait_o, 1);
    kontrol("rst_valid", iomem_valid_o, 0);
    kontrol("rst_addr", iomem_addr_o, 0);
    kontrol("rst_wstrb", iomem_wstrb_o, 0);
    kontrol("rst_okunan", okunan_veri_obegi_o, 0);
    kontrol("rst_pulses", {bbellek_hazir_o, vbellek_hazir_o, hata_o}, 0);
    rst_i = 1'b0;

    // Instruction block read, two waiting cycles per beat.
    @(negedge clk);
    kuyruk_temizle();
    gecikme = 2;
    veri_taban = 32'hA0;
    bbellek_adres_i = 32'h0000_1234;
    bbellek_istek_i = 1'b1;
    hazir_bekle(n, iz, m1);
    bbellek_istek_i = 1'b0;
    kontrol("oku_b_hazir", bbellek_hazir_o, 1);
    kontrol("oku_v_hazir", vbellek_hazir_o, 0);
    kontrol("oku_hata", hata_o, 0);
    kontrol("oku_okunan", okunan_veri_obegi_o, 128'h000000A3_000000A2_000000A1_000000A0);
    beatler_kontrol("oku", 32'h0000_1230, '0, 4'h0);
    @(negedge clk);
    kontrol("oku_tek_darbe", bbellek_hazir_o, 0);
    kontrol("oku_musait", anabellek_musait_o, 1);

    // Data write-back; inputs are scrambled after grant and must be ignored.
    kuyruk_temizle();
    gecikme = 1;
    vbellek_adres_i = 32'h8000_0040;
    vbellek_yaz_i = 1'b1;
    yazilacak_veri_obegi_i = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    vbellek_istek_i = 1'b1;
    repeat (3) @(negedge clk);
    vbellek_adres_i = 32'hDEAD_0000;
    vbellek_yaz_i = 1'b0;
    yazilacak_veri_obegi_i = ~yazilacak_veri_obegi_i;
    hazir_bekle(n, iz, m1);
    vbellek_istek_i = 1'b0;
    kontrol("yaz_v_hazir", vbellek_hazir_o, 1);
    kontrol("yaz_b_hazir", bbellek_hazir_o, 0);
    beatler_kontrol("yaz", 32'h8000_0040, {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 4'hF);
    kontrol("yaz_okunan_sabit", okunan_veri_obegi_o,
            128'h000000A3_000000A2_000000A1_000000A0);
    @(negedge clk);
    kontrol("yaz_tek_darbe", vbellek_hazir_o, 0);

    // Contention straight after reset, zero-latency memory.
    sifirla();
    kuyruk_temizle();
    gecikme = 0;
    veri_taban = 32'hB0;
    bbellek_adres_i = 32'h0000_2000;
    vbellek_adres_i = 32'h0000_3000;
    vbellek_yaz_i = 1'b0;
    bbellek_istek_i = 1'b1;
    vbellek_istek_i = 1'b1;
    hazir_bekle(n, iz, m1);
    bbellek_istek_i = 1'b0;
    veri_taban = 32'hC0;
    kontrol("cekisme1_b_hazir", bbellek_hazir_o, 1);
    kontrol("cekisme1_v_hazir", vbellek_hazir_o, 0);
    kontrol("ardarda_gecikme", n, 8);
    kontrol("ardarda_valid_izi", iz, 16'h0055);
    kontrol("ardarda_mesgul", m1, 0);
    kontrol("cekisme1_okunan", okunan_veri_obegi_o, okuma_blogu(32'hB0));
    beatler_kontrol("cekisme1", 32'h0000_2000, '0, 4'h0);
    @(negedge clk);
    kuyruk_temizle();
    bbellek_adres_i = 32'h0000_4000;
    bbellek_istek_i = 1'b1;
    hazir_bekle(n, iz, m1);
    vbellek_istek_i = 1'b0;
    veri_taban = 32'hD0;
    kontrol("cekisme2_v_hazir", vbellek_hazir_o, 1);
    kontrol("cekisme2_b_hazir", bbellek_hazir_o, 0);
    kontrol("cekisme2_okunan", okunan_veri_obegi_o, okuma_blogu(32'hC0));
    beatler_kontrol("cekisme2", 32'h0000_3000, '0, 4'h0);
    @(negedge clk);
    kuyruk_temizle();
    hazir_bekle(n, iz, m1);
    bbellek_istek_i = 1'b0;
    kontrol("cekisme3_b_hazir", bbellek_hazir_o, 1);
    kontrol("cekisme3_okunan", okunan_veri_obegi_o, okuma_blogu(32'hD0));
    kontrol("cekisme3_adr0", adr_q.size() > 0 ? adr_q[0] : 32'hFFFF_FFFF, 32'h0000_4000);
    @(negedge clk);

    // Timeout: memory never answers.
    mem_acik = 1'b0;
    vbellek_adres_i = 32'h0000_5000;
    vbellek_yaz_i = 1'b0;
    vbellek_istek_i = 1'b1;
    hazir_bekle(n, iz, m1);
    vbellek_istek_i = 1'b0;
    kontrol("zaman_gecikme", n, 9);
    kontrol("zaman_valid_izi", iz, 16'h00FF);
    kontrol("zaman_hata", hata_o, 1);
    kontrol("zaman_v_hazir", vbellek_hazir_o, 1);
    kontrol("zaman_b_hazir", bbellek_hazir_o, 0);
    @(negedge clk);
    kontrol("zaman_musait", anabellek_musait_o, 1);
    kontrol("zaman_hata_darbe", hata_o, 0);
    mem_acik = 1'b1;

    // Reset during beat 2, then a fresh request.
    kuyruk_temizle();
    gecikme = 1;
    veri_taban = 32'hE0;
    bbellek_adres_i = 32'h0000_6000;
    bbellek_istek_i = 1'b1;
    sinir = 0;
    while (!(iomem_valid_o && iomem_addr_o[3:2] == 2'd2) && sinir < 50) begin
      @(negedge clk);
      sinir++;
    end
    kontrol("rst_orta_beat2", iomem_addr_o, 32'h0000_6008);
    rst_i = 1'b1;
    #1;
    kontrol("rst_orta_valid", iomem_valid_o, 0);
    kontrol("rst_orta_musait", anabellek_musait_o, 1);
    bbellek_istek_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    gorulen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      gorulen = gorulen | bbellek_hazir_o | vbellek_hazir_o;
    end
    kontrol("rst_orta_hazir_yok", gorulen, 0);
    kuyruk_temizle();
    bbellek_istek_i = 1'b1;
    hazir_bekle(n, iz, m1);
    bbellek_istek_i = 1'b0;
    kontrol("rst_sonra_b_hazir", bbellek_hazir_o, 1);
    kontrol("rst_sonra_okunan", okunan_veri_obegi_o, okuma_blogu(32'hE0));
    beatler_kontrol("rst_sonra", 32'h0000_6000, '0, 4'h0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
    $finish;
  end

endmodule

// File: doc/anabellek_hakem.md
Name: anabellek_hakem

Overview:
- Arbitrates the single 32-bit iomem main-memory port between the instruction cache (bbellek) and the data cache (vbellek).
- Sequences each granted 128-bit block transfer as four 32-bit iomem beats, either a block refill read or a dirty-block write-back.
- Sits between the two cache wrappers and the top-level iomem pins.
- Provides per-requester done pulses and an error pulse on timeout.

Parameters:
- ZAMAN_ASIMI, 1024: maximum cycles to wait for iomem_ready_i on one beat before aborting. 0 disables the timeout.
- SAYAC_BIT, 11: width of the timeout counter. Must satisfy 2^SAYAC_BIT > ZAMAN_ASIMI.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- bbellek_istek_i  in  1  instruction-cache block read request (level, held until done).
- bbellek_adres_i  in  32  instruction-cache block address (bits [3:0] ignored).
- vbellek_istek_i  in  1  data-cache request (level, held until done).
- vbellek_yaz_i  in  1  1 = write-back of a dirty block, 0 = block read.
- vbellek_adres_i  in  32  data-cache block address (bits [3:0] ignored).
- yazilacak_veri_obegi_i  in  128  write-back block; word k = bits [32k+31:32k].
- iomem_ready_i  in  1  memory beat acknowledge.
- iomem_rdata_i  in  32  memory read data, valid when iomem_ready_i is high.
- iomem_valid_o  out  1  beat request.
- iomem_addr_o  out  32  beat address.
- iomem_wdata_o  out  32  beat write data.
- iomem_wstrb_o  out  4  4'hF on write beats, 4'h0 on read beats.
- anabellek_musait_o  out  1  arbiter idle, no transfer owned.
- okunan_veri_obegi_o  out  128  assembled read block; held stable until the next read completes.
- bbellek_hazir_o  out  1  one-cycle done pulse to the instruction cache.
- vbellek_hazir_o  out  1  one-cycle done pulse to the data cache.
- hata_o  out  1  one-cycle pulse, coincident with the hazir pulse, when a transfer aborted on timeout.

Behaviour:
- Reset values (asynchronous, applied immediately):
  - All outputs are 0 except anabellek_musait_o = 1.
  - State is BOSTA, beat counter 0, timeout counter 0, son_kazanan = vbellek.
  - A reset during a transfer drops iomem_valid_o in the same cycle; no hazir pulse is issued.
- States: BOSTA, ISTEK, ARA, TAMAM.
- BOSTA:
  - anabellek_musait_o = 1.
  - If only one request is high, grant it.
  - If both are high, grant the requester that is not son_kazanan (round-robin).
  - On grant: latch owner, write flag (forced 0 for bbellek), address [31:4], and the write block; set son_kazanan; beat = 0; go to ISTEK.
- ISTEK:
  - iomem_valid_o = 1.
  - iomem_addr_o = {adres[31:4], beat[1:0], 2'b00}.
  - iomem_wdata_o = latched word[beat] on writes, 0 on reads.
  - iomem_wstrb_o = write ? 4'hF : 4'h0.
  - The timeout counter increments every cycle in this state.
  - On iomem_ready_i:
    - Reads store iomem_rdata_i into okunan_veri_obegi_o word[beat].
    - Clear the timeout counter.
    - If beat == 3, go to TAMAM; otherwise increment beat and go to ARA.
  - If ZAMAN_ASIMI != 0, the counter reaches ZAMAN_ASIMI, and ready is low: set the error flag and go to TAMAM.
- ARA:
  - iomem_valid_o = 0 for exactly one cycle, so every beat is a distinct iomem transaction.
  - Then go to ISTEK.
- TAMAM:
  - Pulse the owner's hazir output for one cycle; pulse hata_o in the same cycle if the error flag is set.
  - Clear the flag and go to BOSTA.
  - On abort, okunan_veri_obegi_o holds the partial block, which is undefined to consumers.
- Latency: with ready in the first valid cycle of every beat, beats complete on cycles 1, 3, 5, 7 after grant and hazir pulses on cycle 8.
- Busy handling: the arbiter holds anabellek_musait_o = 0 from the cycle after grant until back in BOSTA.
- Requester rules:
  - Requests arriving while busy wait; they are not lost, since requesters hold level.
  - A requester must drop istek the cycle after its hazir pulse. If istek is still high in BOSTA, it is treated as a new request.
- Input stability: changes to address, data, or yaz after grant are ignored.
- A ready asserted while valid is low (ARA or BOSTA) is ignored.
- Simultaneous ready and timeout expiry: ready wins.

Test Plan:
- Instruction read: bbellek_istek_i = 1, adres = 32'h0000_1234, memory returns ready after 2 cycles with data 32'hA0 + beat. Required: addresses 0x1230, 0x1234, 0x1238, 0x123C; wstrb 0; okunan_veri_obegi_o = 128'h000000A3_000000A2_000000A1_000000A0; one bbellek_hazir_o pulse.
- Data write-back: vbellek_yaz_i = 1, adres = 32'h8000_0040, block = 128'h4444_3333_2222_1111 per word. Required: wdata 1111, 2222, 3333, 4444 in order at 0x8000_0040 to 0x8000_004C; wstrb F; one vbellek_hazir_o pulse; okunan_veri_obegi_o unchanged.
- Contention: both requests rise in the same cycle after reset. Required: bbellek is served first (son_kazanan reset = vbellek), then vbellek, then bbellek again if it re-requests.
- Timeout: ZAMAN_ASIMI = 8, ready held low. Required: valid high 8 cycles, then hata_o and vbellek_hazir_o pulse together, musait returns to 1.
- Reset mid-transfer: assert rst_i during beat 2. Required: iomem_valid_o = 0 immediately, no hazir pulse; after release, a fresh request restarts at beat 0.
- Back-to-back: ready is zero-latency. Required: hazir exactly 8 cycles after grant; valid toggles high-low between beats.
